// File: rtl/sipo_drain.sv
// sipo_drain: AXI4-Lite master that switches the sipo capture block on,
// polls its STATUS register, reads every captured word out of DATA and
// hands each word to a valid/ready stream. Switches capture off again on
// stop or once MAX_WORDS words have been delivered.
// All outputs come straight from registers; the FSM is a state register
// plus a combinational next-state/next-output process.

`ifndef AXI4_ADDR_BITS
`define AXI4_ADDR_BITS 32
`endif
`ifndef AXI4_DATA_BITS
`define AXI4_DATA_BITS 32
`endif
`ifndef AXI4_STRB_BITS
`define AXI4_STRB_BITS 4
`endif
`ifndef AXI4_PROT_BITS
`define AXI4_PROT_BITS 3
`endif
`ifndef AXI4_RESP_BITS
`define AXI4_RESP_BITS 2
`endif
`ifndef MMIO_BASE_ADDR
`define MMIO_BASE_ADDR 32'h4000_0000
`endif

module sipo_drain #(
    parameter logic [`AXI4_ADDR_BITS-1:0] BASE_ADDR = `MMIO_BASE_ADDR,
    parameter logic [`AXI4_DATA_BITS-1:0] CTRL_ON   = 32'h0000_0003,
    parameter logic [`AXI4_DATA_BITS-1:0] CTRL_OFF  = 32'h0000_0002,
    parameter int unsigned                POLL_GAP  = 4,
    parameter logic [31:0]                MAX_WORDS = 32'd0
) (
    input  logic                         s_axi4lite_clk,
    input  logic                         s_axi4lite_rstn,
    input  logic                         start,
    input  logic                         stop,
    output logic                         m_axi4lite_aw_valid,
    input  logic                         m_axi4lite_aw_ready,
    output logic [`AXI4_ADDR_BITS-1:0]   m_axi4lite_aw_addr,
    output logic [`AXI4_PROT_BITS-1:0]   m_axi4lite_aw_prot,
    output logic                         m_axi4lite_w_valid,
    input  logic                         m_axi4lite_w_ready,
    output logic [`AXI4_DATA_BITS-1:0]   m_axi4lite_w_data,
    output logic [`AXI4_STRB_BITS-1:0]   m_axi4lite_w_strb,
    input  logic                         m_axi4lite_b_valid,
    output logic                         m_axi4lite_b_ready,
    input  logic [`AXI4_RESP_BITS-1:0]   m_axi4lite_b_resp,
    output logic                         m_axi4lite_ar_valid,
    input  logic                         m_axi4lite_ar_ready,
    output logic [`AXI4_ADDR_BITS-1:0]   m_axi4lite_ar_addr,
    output logic [`AXI4_PROT_BITS-1:0]   m_axi4lite_ar_prot,
    input  logic                         m_axi4lite_r_valid,
    output logic                         m_axi4lite_r_ready,
    input  logic [`AXI4_DATA_BITS-1:0]   m_axi4lite_r_data,
    input  logic [`AXI4_RESP_BITS-1:0]   m_axi4lite_r_resp,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [`AXI4_DATA_BITS-1:0]   out_data,
    output logic                         busy,
    output logic [31:0]                  word_count,
    output logic                         err
);

    localparam int AW = `AXI4_ADDR_BITS;
    localparam int DW = `AXI4_DATA_BITS;
    localparam int RW = `AXI4_RESP_BITS;

    localparam logic [AW-1:0] ADDR_DATA   = BASE_ADDR;
    localparam logic [AW-1:0] ADDR_STATUS = BASE_ADDR + AW'(4'h8);
    localparam logic [AW-1:0] ADDR_CTRL   = BASE_ADDR + AW'(4'hC);
    localparam logic [RW-1:0] RESP_OKAY   = {RW{1'b0}};
    // GAP runs POLL_GAP cycles: counter values 0 .. POLL_GAP-1
    localparam logic [15:0]   GAP_LAST    = 16'(POLL_GAP - 1);

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_CFG_ON  = 4'd1,
        ST_POLL_AR = 4'd2,
        ST_POLL_R  = 4'd3,
        ST_GAP     = 4'd4,
        ST_DATA_AR = 4'd5,
        ST_DATA_R  = 4'd6,
        ST_OUT     = 4'd7,
        ST_CFG_OFF = 4'd8
    } state_t;

    state_t          state_r,      state_s;
    logic [15:0]     gap_cnt_r,    gap_cnt_s;
    logic            aw_valid_r,   aw_valid_s;
    logic            w_valid_r,    w_valid_s;
    logic [AW-1:0]   aw_addr_r,    aw_addr_s;
    logic [DW-1:0]   w_data_r,     w_data_s;
    logic            b_ready_r,    b_ready_s;
    logic            ar_valid_r,   ar_valid_s;
    logic [AW-1:0]   ar_addr_r,    ar_addr_s;
    logic            r_ready_r,    r_ready_s;
    logic            out_valid_r,  out_valid_s;
    logic [DW-1:0]   out_data_r,   out_data_s;
    logic [31:0]     word_count_r, word_count_s;
    logic            err_r,        err_s;
    logic            busy_r,       busy_s;
    logic [31:0]     count_inc_s;
    logic            limit_hit_s;

    // Next-state and next-output logic; every register holds unless changed
    always_comb begin
        state_s      = state_r;
        gap_cnt_s    = gap_cnt_r;
        // each valid falls on its own handshake, independent of the others
        aw_valid_s   = aw_valid_r & ~m_axi4lite_aw_ready;
        w_valid_s    = w_valid_r  & ~m_axi4lite_w_ready;
        ar_valid_s   = ar_valid_r & ~m_axi4lite_ar_ready;
        aw_addr_s    = aw_addr_r;
        w_data_s     = w_data_r;
        b_ready_s    = b_ready_r;
        ar_addr_s    = ar_addr_r;
        r_ready_s    = r_ready_r;
        out_valid_s  = out_valid_r;
        out_data_s   = out_data_r;
        word_count_s = word_count_r;
        err_s        = err_r;
        count_inc_s  = word_count_r + 32'd1;
        limit_hit_s  = (MAX_WORDS != 32'd0) && (count_inc_s == MAX_WORDS);

        case (state_r)
            ST_IDLE: begin
                if (start && !stop) begin
                    err_s        = 1'b0;
                    word_count_s = 32'd0;
                    state_s      = ST_CFG_ON;
                    aw_valid_s   = 1'b1;
                    w_valid_s    = 1'b1;
                    aw_addr_s    = ADDR_CTRL;
                    w_data_s     = CTRL_ON;
                    b_ready_s    = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_CFG_ON, ST_CFG_OFF: begin
                if (b_ready_r && m_axi4lite_b_valid) begin
                    b_ready_s  = 1'b0;
                    aw_valid_s = 1'b0;
                    w_valid_s  = 1'b0;
                    if (m_axi4lite_b_resp != RESP_OKAY) begin
                        err_s   = 1'b1;
                        state_s = ST_IDLE;
                    end else if (state_r == ST_CFG_ON) begin
                        state_s    = ST_POLL_AR;
                        ar_valid_s = 1'b1;
                        ar_addr_s  = ADDR_STATUS;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = state_r;
                end
            end

            ST_POLL_AR, ST_DATA_AR: begin
                if (ar_valid_r && m_axi4lite_ar_ready) begin
                    r_ready_s = 1'b1;
                    state_s   = (state_r == ST_POLL_AR) ? ST_POLL_R : ST_DATA_R;
                end else begin
                    state_s = state_r;
                end
            end

            ST_POLL_R: begin
                if (r_ready_r && m_axi4lite_r_valid) begin
                    r_ready_s = 1'b0;
                    if (m_axi4lite_r_resp != RESP_OKAY) begin
                        err_s   = 1'b1;
                        state_s = ST_IDLE;
                    end else if (m_axi4lite_r_data[0]) begin
                        state_s    = ST_DATA_AR;
                        ar_valid_s = 1'b1;
                        ar_addr_s  = ADDR_DATA;
                    end else if (stop) begin
                        state_s    = ST_CFG_OFF;
                        aw_valid_s = 1'b1;
                        w_valid_s  = 1'b1;
                        aw_addr_s  = ADDR_CTRL;
                        w_data_s   = CTRL_OFF;
                        b_ready_s  = 1'b1;
                    end else begin
                        state_s   = ST_GAP;
                        gap_cnt_s = 16'd0;
                    end
                end else begin
                    state_s = ST_POLL_R;
                end
            end

            ST_GAP: begin
                if (stop) begin
                    state_s    = ST_CFG_OFF;
                    aw_valid_s = 1'b1;
                    w_valid_s  = 1'b1;
                    aw_addr_s  = ADDR_CTRL;
                    w_data_s   = CTRL_OFF;
                    b_ready_s  = 1'b1;
                end else if (gap_cnt_r == GAP_LAST) begin
                    state_s    = ST_POLL_AR;
                    ar_valid_s = 1'b1;
                    ar_addr_s  = ADDR_STATUS;
                end else begin
                    gap_cnt_s = gap_cnt_r + 16'd1;
                end
            end

            ST_DATA_R: begin
                if (r_ready_r && m_axi4lite_r_valid) begin
                    r_ready_s = 1'b0;
                    if (m_axi4lite_r_resp != RESP_OKAY) begin
                        // the word is discarded and capture is left as is
                        err_s   = 1'b1;
                        state_s = ST_IDLE;
                    end else begin
                        out_data_s  = m_axi4lite_r_data;
                        out_valid_s = 1'b1;
                        state_s     = ST_OUT;
                    end
                end else begin
                    state_s = ST_DATA_R;
                end
            end

            ST_OUT: begin
                if (out_valid_r && out_ready) begin
                    out_valid_s  = 1'b0;
                    word_count_s = count_inc_s;
                    if (stop || limit_hit_s) begin
                        state_s    = ST_CFG_OFF;
                        aw_valid_s = 1'b1;
                        w_valid_s  = 1'b1;
                        aw_addr_s  = ADDR_CTRL;
                        w_data_s   = CTRL_OFF;
                        b_ready_s  = 1'b1;
                    end else begin
                        state_s    = ST_POLL_AR;
                        ar_valid_s = 1'b1;
                        ar_addr_s  = ADDR_STATUS;
                    end
                end else begin
                    state_s = ST_OUT;
                end
            end

            default: begin
                state_s     = ST_IDLE;
                aw_valid_s  = 1'b0;
                w_valid_s   = 1'b0;
                ar_valid_s  = 1'b0;
                b_ready_s   = 1'b0;
                r_ready_s   = 1'b0;
                out_valid_s = 1'b0;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge s_axi4lite_clk) begin
        if (!s_axi4lite_rstn) begin
            state_r      <= ST_IDLE;
            gap_cnt_r    <= 16'd0;
            aw_valid_r   <= 1'b0;
            w_valid_r    <= 1'b0;
            aw_addr_r    <= {AW{1'b0}};
            w_data_r     <= {DW{1'b0}};
            b_ready_r    <= 1'b0;
            ar_valid_r   <= 1'b0;
            ar_addr_r    <= {AW{1'b0}};
            r_ready_r    <= 1'b0;
            out_valid_r  <= 1'b0;
            out_data_r   <= {DW{1'b0}};
            word_count_r <= 32'd0;
            err_r        <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            gap_cnt_r    <= gap_cnt_s;
            aw_valid_r   <= aw_valid_s;
            w_valid_r    <= w_valid_s;
            aw_addr_r    <= aw_addr_s;
            w_data_r     <= w_data_s;
            b_ready_r    <= b_ready_s;
            ar_valid_r   <= ar_valid_s;
            ar_addr_r    <= ar_addr_s;
            r_ready_r    <= r_ready_s;
            out_valid_r  <= out_valid_s;
            out_data_r   <= out_data_s;
            word_count_r <= word_count_s;
            err_r        <= err_s;
            busy_r       <= busy_s;
        end
    end

    assign m_axi4lite_aw_valid = aw_valid_r;
    assign m_axi4lite_aw_addr  = aw_addr_r;
    assign m_axi4lite_aw_prot  = {`AXI4_PROT_BITS{1'b0}};
    assign m_axi4lite_w_valid  = w_valid_r;
    assign m_axi4lite_w_data   = w_data_r;
    assign m_axi4lite_w_strb   = {`AXI4_STRB_BITS{1'b1}};
    assign m_axi4lite_b_ready  = b_ready_r;
    assign m_axi4lite_ar_valid = ar_valid_r;
    assign m_axi4lite_ar_addr  = ar_addr_r;
    assign m_axi4lite_ar_prot  = {`AXI4_PROT_BITS{1'b0}};
    assign m_axi4lite_r_ready  = r_ready_r;
    assign out_valid           = out_valid_r;
    assign out_data            = out_data_r;
    assign word_count          = word_count_r;
    assign err                 = err_r;
    assign busy                = busy_r;

endmodule

// File: tb/tb_sipo_drain.sv
// Bench for sipo_drain: a procedural AXI4-Lite slave answers the DUT's
// transactions; every DATA word the slave returns with OKAY is pushed to a
// scoreboard queue and popped when the DUT delivers it on the out stream.
// All DUT outputs are sampled on the falling edge.

module tb_sipo_drain;

    localparam logic [31:0] BASE    = 32'h4000_0000;
    localparam logic [31:0] A_DATA  = BASE;
    localparam logic [31:0] A_STAT  = BASE + 32'h8;
    localparam logic [31:0] A_CTRL  = BASE + 32'hC;
    localparam logic [1:0]  OKAY    = 2'b00;
    localparam logic [1:0]  SLVERR  = 2'b10;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        aw_valid, aw_ready = 1'b1;
    logic [31:0] aw_addr;
    logic [2:0]  aw_prot;
    logic        w_valid, w_ready = 1'b1;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        b_valid = 1'b0, b_ready;
    logic [1:0]  b_resp = 2'b00;
    logic        ar_valid, ar_ready = 1'b1;
    logic [31:0] ar_addr;
    logic [2:0]  ar_prot;
    logic        r_valid = 1'b0, r_ready;
    logic [31:0] r_data = 32'd0;
    logic [1:0]  r_resp = 2'b00;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] out_data;
    logic        busy;
    logic [31:0] word_count;
    logic        err;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q[$];

    sipo_drain #(
        .BASE_ADDR (BASE),
        .CTRL_ON   (32'h0000_0003),
        .CTRL_OFF  (32'h0000_0002),
        .POLL_GAP  (4),
        .MAX_WORDS (32'd3)
    ) dut (
        .s_axi4lite_clk      (clk),
        .s_axi4lite_rstn     (rstn),
        .start               (start),
        .stop                (stop),
        .m_axi4lite_aw_valid (aw_valid),
        .m_axi4lite_aw_ready (aw_ready),
        .m_axi4lite_aw_addr  (aw_addr),
        .m_axi4lite_aw_prot  (aw_prot),
        .m_axi4lite_w_valid  (w_valid),
        .m_axi4lite_w_ready  (w_ready),
        .m_axi4lite_w_data   (w_data),
        .m_axi4lite_w_strb   (w_strb),
        .m_axi4lite_b_valid  (b_valid),
        .m_axi4lite_b_ready  (b_ready),
        .m_axi4lite_b_resp   (b_resp),
        .m_axi4lite_ar_valid (ar_valid),
        .m_axi4lite_ar_ready (ar_ready),
        .m_axi4lite_ar_addr  (ar_addr),
        .m_axi4lite_ar_prot  (ar_prot),
        .m_axi4lite_r_valid  (r_valid),
        .m_axi4lite_r_ready  (r_ready),
        .m_axi4lite_r_data   (r_data),
        .m_axi4lite_r_resp   (r_resp),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_data            (out_data),
        .busy                (busy),
        .word_count          (word_count),
        .err                 (err)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Hard time limit in case a bounded wait was miscounted
    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "time limit");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait for a CTRL write, check it, then return a B response
    task automatic slave_write(input string tag, input logic [31:0] exp_data, input logic [1:0] resp);
        int n = 0;
        while (!(aw_valid && w_valid) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_seen"}, 32'(aw_valid && w_valid), 32'd1);
        check_val({tag, "_addr"}, aw_addr, A_CTRL);
        check_val({tag, "_data"}, w_data, exp_data);
        check_val({tag, "_strb_prot"}, {25'd0, w_strb, aw_prot}, {25'd0, 4'hF, 3'd0});
        check_val({tag, "_no_ar"}, 32'(ar_valid), 32'd0);
        @(negedge clk);
        check_val({tag, "_valids_drop"}, {30'd0, aw_valid, w_valid}, 32'd0);
        check_val({tag, "_b_ready"}, 32'(b_ready), 32'd1);
        b_valid = 1'b1;
        b_resp  = resp;
        @(negedge clk);
        b_valid = 1'b0;
        b_resp  = OKAY;
    endtask

    // Wait for a read, check its address, then return R data; idle = cycles waited
    task automatic slave_read(input string tag, input logic [31:0] exp_addr, input logic [31:0] data,
                              input logic [1:0] resp, output int idle);
        idle = 0;
        while (!ar_valid && idle < 100) begin
            @(negedge clk);
            idle++;
        end
        check_val({tag, "_seen"}, 32'(ar_valid), 32'd1);
        check_val({tag, "_addr"}, ar_addr, exp_addr);
        check_val({tag, "_no_aw"}, {29'd0, aw_valid, w_valid, 1'b0} | {29'd0, ar_prot}, 32'd0);
        @(negedge clk);
        check_val({tag, "_ar_drop_r_ready"}, {30'd0, ar_valid, r_ready}, 32'd1);
        r_valid = 1'b1;
        r_data  = data;
        r_resp  = resp;
        if (exp_addr == A_DATA && resp == OKAY) exp_q.push_back(data);
        @(negedge clk);
        r_valid = 1'b0;
        r_data  = 32'd0;
        r_resp  = OKAY;
    endtask

    // Accept one output word after holding out_ready low for hold cycles
    task automatic take_out(input string tag, input int hold, input logic [31:0] exp_wc);
        int n = 0;
        logic [31:0] exp_word;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_val({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
        exp_word = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
        for (int i = 0; i < hold; i++) begin
            check_val({tag, "_hold_data"}, out_data, exp_word);
            check_val({tag, "_hold_quiet"}, {30'd0, ar_valid, out_valid}, 32'd1);
            @(negedge clk);
        end
        check_val({tag, "_data"}, out_data, exp_word);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_val({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check_val({tag, "_count"}, word_count, exp_wc);
    endtask

    initial begin
        int idle;

        // reset state
        repeat (3) @(negedge clk);
        check_val("rst_valids", {27'd0, aw_valid, w_valid, ar_valid, b_ready, r_ready}, 32'd0);
        check_val("rst_status", {29'd0, out_valid, busy, err}, 32'd0);
        check_val("rst_count", word_count, 32'd0);
        check_val("rst_addr", aw_addr | ar_addr | w_data | out_data, 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // session 1: gap timing, back-pressure, auto-stop at three words
        pulse_start();
        slave_write("s1_on", 32'h3, OKAY);
        check_val("s1_busy_err", {30'd0, busy, err}, 32'd2);
        check_val("s1_count0", word_count, 32'd0);
        for (int i = 0; i < 4; i++) begin
            slave_read("s1_poll", A_STAT, (i < 3) ? 32'h0 : 32'h1, OKAY, idle);
            check_val("s1_poll_idle", 32'(idle), (i == 0) ? 32'd0 : 32'd4);
        end
        slave_read("s1_data", A_DATA, 32'hDEAD_BEEF, OKAY, idle);
        check_val("s1_data_idle", 32'(idle), 32'd0);
        take_out("s1_out0", 10, 32'd1);
        slave_read("s1_poll", A_STAT, 32'h1, OKAY, idle);
        check_val("s1_poll_after_out", 32'(idle), 32'd0);
        slave_read("s1_data", A_DATA, 32'h0000_0011, OKAY, idle);
        take_out("s1_out1", 2, 32'd2);
        slave_read("s1_poll", A_STAT, 32'h1, OKAY, idle);
        slave_read("s1_data", A_DATA, 32'h0000_0022, OKAY, idle);
        take_out("s1_out2", 0, 32'd3);
        slave_write("s1_off", 32'h2, OKAY);
        check_val("s1_idle", {31'd0, busy}, 32'd0);
        check_val("s1_final_count", word_count, 32'd3);

        // session 2: fresh session, data 1,2,3
        pulse_start();
        check_val("s2_count_clr", word_count, 32'd0);
        slave_write("s2_on", 32'h3, OKAY);
        for (int i = 1; i <= 3; i++) begin
            slave_read("s2_poll", A_STAT, 32'h1, OKAY, idle);
            slave_read("s2_data", A_DATA, 32'(i), OKAY, idle);
            take_out("s2_out", 1, 32'(i));
        end
        slave_write("s2_off", 32'h2, OKAY);
        check_val("s2_done", {30'd0, busy, err}, 32'd0);
        check_val("s2_count", word_count, 32'd3);

        // session 3: stop raised while the DATA read is pending
        pulse_start();
        slave_write("s3_on", 32'h3, OKAY);
        slave_read("s3_poll", A_STAT, 32'h1, OKAY, idle);
        stop = 1'b1;
        slave_read("s3_data", A_DATA, 32'hCAFE_0001, OKAY, idle);
        take_out("s3_out", 0, 32'd1);
        slave_write("s3_off", 32'h2, OKAY);
        check_val("s3_idle", {31'd0, busy}, 32'd0);

        // start together with stop: nothing happens
        start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_val("ss_quiet", {29'd0, aw_valid, ar_valid, busy}, 32'd0);
        end
        start = 1'b0;
        stop  = 1'b0;

        // session 4: stop during the poll gap
        pulse_start();
        slave_write("s4_on", 32'h3, OKAY);
        slave_read("s4_poll", A_STAT, 32'h0, OKAY, idle);
        stop = 1'b1;
        slave_write("s4_off", 32'h2, OKAY);
        check_val("s4_idle", {31'd0, busy}, 32'd0);
        check_val("s4_count", word_count, 32'd0);
        stop = 1'b0;

        // session 5: SLVERR on the DATA read
        pulse_start();
        slave_write("s5_on", 32'h3, OKAY);
        slave_read("s5_poll", A_STAT, 32'h1, OKAY, idle);
        slave_read("s5_data", A_DATA, 32'hBAD0_BAD0, SLVERR, idle);
        check_val("s5_err", {30'd0, err, busy}, 32'd2);
        for (int i = 0; i < 6; i++) begin
            check_val("s5_quiet", {29'd0, out_valid, aw_valid, ar_valid}, 32'd0);
            @(negedge clk);
        end

        // next start clears err; then reset while AW is waiting
        aw_ready = 1'b0;
        w_ready  = 1'b0;
        pulse_start();
        check_val("s6_err_clr", {30'd0, err, busy}, 32'd1);
        check_val("s6_aw_wait", {30'd0, aw_valid, w_valid}, 32'd3);
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check_val("s6_rst_valids", {26'd0, aw_valid, w_valid, ar_valid, b_ready, r_ready, out_valid}, 32'd0);
        check_val("s6_rst_busy", {30'd0, busy, err}, 32'd0);
        rstn     = 1'b1;
        aw_ready = 1'b1;
        w_ready  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("s6_no_resume", {29'd0, aw_valid, ar_valid, busy}, 32'd0);
        end

        check_val("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
